// File: rtl/spdif_pkg.sv
// Shared constants and types for the S/PDIF transmitter: preamble patterns,
// frame geometry, slot map and the per-half-cell encoder request.
package spdif_pkg;

    // Preambles as sent after a low level, first half-cell in the MSB
    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    localparam int BLOCK_FRAMES = 192;
    localparam int HC_PER_FRAME = 128;

    localparam logic [4:0] SLOT_AUD_LO = 5'd4;
    localparam logic [4:0] SLOT_V      = 5'd28;
    localparam logic [4:0] SLOT_U      = 5'd29;
    localparam logic [4:0] SLOT_C      = 5'd30;
    localparam logic [4:0] SLOT_P      = 5'd31;

    typedef struct packed {
        logic is_pre;
        logic pre_bit;
        logic data_bit;
        logic half;
    } bmc_hc_t;

    function automatic logic [7:0] preamble_sel(input logic right, input logic first_frame);
        if (right)       return PRE_W;
        if (first_frame) return PRE_B;
        return PRE_M;
    endfunction

endpackage

// File: rtl/spdif_bmc_enc.sv
// Biphase-mark line encoder: one registered output level per half-cell,
// preambles inverted relative to the level that precedes them.
module spdif_bmc_enc
    import spdif_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  bmc_hc_t hc_in,
    output logic    spdif
);

    logic level_q, level_d;
    logic inv_q, inv_d;
    logic in_pre_q, in_pre_d;
    logic inv_now;

    always_comb begin
        // Polarity is fixed on the first preamble half-cell and held for the rest of it
        inv_now  = (hc_in.is_pre && !in_pre_q) ? level_q : inv_q;
        inv_d    = inv_now;
        in_pre_d = hc_in.is_pre;
        if (hc_in.is_pre)
            level_d = hc_in.pre_bit ^ inv_now;
        else if (!hc_in.half)
            level_d = ~level_q;
        else
            level_d = level_q ^ hc_in.data_bit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q  <= 1'b0;
            inv_q    <= 1'b0;
            in_pre_q <= 1'b0;
        end else begin
            level_q  <= level_d;
            inv_q    <= inv_d;
            in_pre_q <= in_pre_d;
        end
    end

    assign spdif = level_q;

endmodule

// File: rtl/spdif_transmit.sv
// IEC 60958 consumer transmitter: half-cell/frame counters, sample holding and
// frame-load logic, subframe slot mux and parity; line coding is in spdif_bmc_enc.
module spdif_transmit
    import spdif_pkg::*;
#(
    parameter logic [31:0] CS_WORD  = 32'h0200_0004,
    parameter logic        VALIDITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_left,
    input  logic [31:0] data_right,
    input  logic        sample_valid,
    output logic        spdif,
    output logic        frame_start,
    output logic        block_start,
    output logic        underrun
);

    localparam logic [6:0] LAST_HC    = 7'(HC_PER_FRAME - 1);
    localparam logic [7:0] LAST_FRAME = 8'(BLOCK_FRAMES - 1);

    logic [6:0]  hc_q, hc_d;
    logic [7:0]  frame_q, frame_d;
    logic [23:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [23:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic        new_flag_q, new_flag_d;
    logic        urun_pend_q, urun_pend_d;
    logic        frame_start_q, frame_start_d;
    logic        block_start_q, block_start_d;
    logic        underrun_q, underrun_d;

    logic        load;
    logic        subframe;
    logic [4:0]  slot;
    logic [23:0] aud;
    logic [31:0] aud_ext;
    logic        c_bit, parity, data_bit;
    logic [7:0]  pre_pat;
    bmc_hc_t     hc_enc;

    // Only the 24-bit audio word is transmitted
    logic unused_lsbs;
    assign unused_lsbs = ^{data_left[7:0], data_right[7:0]};

    always_comb begin
        load     = (hc_q == LAST_HC);
        subframe = hc_q[6];
        slot     = hc_q[5:1];
        aud      = subframe ? sh_r_q : sh_l_q;
        aud_ext  = {8'd0, aud};
        c_bit    = (frame_q[7:5] == 3'd0) ? CS_WORD[frame_q[4:0]] : 1'b0;
        parity   = ^{aud, VALIDITY, 1'b0, c_bit};
        pre_pat  = preamble_sel(subframe, frame_q == 8'd0);

        case (slot)
            SLOT_V:  data_bit = VALIDITY;
            SLOT_U:  data_bit = 1'b0;
            SLOT_C:  data_bit = c_bit;
            SLOT_P:  data_bit = parity;
            default: data_bit = aud_ext[slot - SLOT_AUD_LO];
        endcase

        hc_enc.is_pre   = (slot < SLOT_AUD_LO);
        hc_enc.pre_bit  = pre_pat[~hc_q[2:0]];
        hc_enc.data_bit = data_bit;
        hc_enc.half     = hc_q[0];
    end

    always_comb begin
        hc_d        = hc_q + 7'd1;
        frame_d     = frame_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        sh_l_d      = sh_l_q;
        sh_r_d      = sh_r_q;
        new_flag_d  = new_flag_q;
        urun_pend_d = urun_pend_q;

        if (sample_valid) begin
            hold_l_d   = data_left[31:8];
            hold_r_d   = data_right[31:8];
            new_flag_d = 1'b1;
        end

        // A strobe coinciding with the load bypasses the holding regs and counts as fresh
        if (load) begin
            frame_d     = (frame_q == LAST_FRAME) ? 8'd0 : frame_q + 8'd1;
            sh_l_d      = sample_valid ? data_left[31:8]  : hold_l_q;
            sh_r_d      = sample_valid ? data_right[31:8] : hold_r_q;
            new_flag_d  = 1'b0;
            urun_pend_d = !new_flag_q && !sample_valid;
        end

        frame_start_d = (hc_q == 7'd0);
        block_start_d = (hc_q == 7'd0) && (frame_q == 8'd0);
        underrun_d    = (hc_q == 7'd0) && urun_pend_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc_q          <= 7'd0;
            frame_q       <= 8'd0;
            hold_l_q      <= 24'd0;
            hold_r_q      <= 24'd0;
            sh_l_q        <= 24'd0;
            sh_r_q        <= 24'd0;
            new_flag_q    <= 1'b0;
            urun_pend_q   <= 1'b0;
            frame_start_q <= 1'b0;
            block_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            frame_q       <= frame_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            sh_l_q        <= sh_l_d;
            sh_r_q        <= sh_r_d;
            new_flag_q    <= new_flag_d;
            urun_pend_q   <= urun_pend_d;
            frame_start_q <= frame_start_d;
            block_start_q <= block_start_d;
            underrun_q    <= underrun_d;
        end
    end

    spdif_bmc_enc u_enc (
        .clk   (clk),
        .rst   (rst),
        .hc_in (hc_enc),
        .spdif (spdif)
    );

    assign frame_start = frame_start_q;
    assign block_start = block_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_spdif_transmit.sv
// Bench for spdif_transmit: per-frame stimulus table plus random frames feed a
// scoreboard of expected audio/underrun; a line monitor decodes BMC and checks framing.
module tb_spdif_transmit;

    localparam logic [31:0] CS    = 32'h0200_0004;
    localparam logic [7:0]  B_PAT = 8'b11101000;
    localparam logic [7:0]  M_PAT = 8'b11100010;
    localparam logic [7:0]  W_PAT = 8'b11100100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_left = '0;
    logic [31:0] data_right = '0;
    logic        sample_valid = 1'b0;
    logic        spdif, frame_start, block_start, underrun;

    always #5 clk = ~clk;

    spdif_transmit dut (
        .clk          (clk),
        .rst          (rst),
        .data_left    (data_left),
        .data_right   (data_right),
        .sample_valid (sample_valid),
        .spdif        (spdif),
        .frame_start  (frame_start),
        .block_start  (block_start),
        .underrun     (underrun)
    );

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
        logic        u;
    } exp_t;

    // stb[0]/[1]/[2] strobe at hc 40 / 90 / 127 (load cycle); e = what the next frame carries
    typedef struct packed {
        logic [2:0]       stb;
        logic [2:0][31:0] l;
        logic [2:0][31:0] r;
        exp_t             e;
    } vec_t;

    exp_t   sb[$];
    exp_t   cur_e;
    bit     have_e = 1'b0;
    bit     mon_en = 1'b1;
    int     n_cmp = 0;
    int     n_err = 0;
    int     pcnt;
    logic [127:0] hbuf;
    logic   mlast = 1'b0;

    always @(posedge clk or negedge rst)
        if (!rst) pcnt <= 0;
        else      pcnt <= pcnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic decode_sub(input int sub, input int fr);
        int          base;
        int          terr;
        logic        p, prevl, a, b;
        logic [7:0]  pre, ep;
        logic [31:0] bits;
        base = sub * 64;
        p    = sub ? hbuf[63] : mlast;
        for (int i = 0; i < 8; i++) pre[7-i] = hbuf[base+i];
        ep = (sub != 0) ? W_PAT : ((fr == 0) ? B_PAT : M_PAT);
        chk(sub ? "preamble_right" : "preamble_left", {24'd0, pre}, {24'd0, ep ^ {8{p}}});
        bits  = '0;
        terr  = 0;
        prevl = hbuf[base+7];
        for (int s = 4; s < 32; s++) begin
            a = hbuf[base+2*s];
            b = hbuf[base+2*s+1];
            if (a == prevl) terr++;
            bits[s] = a ^ b;
            prevl   = b;
        end
        chk("bmc_cell_edges", terr, 0);
        if (have_e) chk(sub ? "audio_right" : "audio_left", {8'd0, bits[27:4]},
                        {8'd0, sub ? cur_e.r : cur_e.l});
        chk("v_bit", {31'd0, bits[28]}, 32'd0);
        chk("u_bit", {31'd0, bits[29]}, 32'd0);
        chk("c_bit", {31'd0, bits[30]}, {31'd0, (fr < 32) ? CS[fr] : 1'b0});
        chk("parity", {31'd0, ^bits[31:4]}, 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        int k, h, fr;
        if (pcnt == 0) begin
            mlast  = 1'b0;
            have_e = 1'b0;
        end else if (mon_en) begin
            k  = pcnt - 1;
            h  = k % 128;
            fr = (k / 128) % 192;
            hbuf[h] = spdif;
            if (h == 0) begin
                if (sb.size() > 0) begin
                    cur_e  = sb.pop_front();
                    have_e = 1'b1;
                end else begin
                    have_e = 1'b0;
                    n_cmp++;
                    n_err++;
                    $display("FAIL scoreboard: nothing queued for frame %0d", fr);
                end
            end
            chk("frame_start", {31'd0, frame_start}, {31'd0, h == 0});
            chk("block_start", {31'd0, block_start}, {31'd0, h == 0 && fr == 0});
            chk("underrun", {31'd0, underrun}, {31'd0, h == 0 && have_e && cur_e.u});
            if (h == 63) decode_sub(0, fr);
            if (h == 127) begin
                decode_sub(1, fr);
                mlast = hbuf[127];
            end
        end
    end

    function automatic int stb_hc(input int j);
        return (j == 0) ? 40 : (j == 1) ? 90 : 127;
    endfunction

    function automatic vec_t mk(input logic [2:0] stb,
                                input logic [31:0] l0, input logic [31:0] r0,
                                input logic [31:0] l1, input logic [31:0] r1,
                                input logic [31:0] l2, input logic [31:0] r2,
                                input logic [23:0] el, input logic [23:0] er, input logic eu);
        vec_t v;
        v.stb  = stb;
        v.l[0] = l0; v.r[0] = r0;
        v.l[1] = l1; v.r[1] = r1;
        v.l[2] = l2; v.r[2] = r2;
        v.e.l  = el; v.e.r = er; v.e.u = eu;
        return v;
    endfunction

    // Entered at the negedge preceding hc=0; returns at the negedge preceding the next hc=0
    task automatic drive_frame(input vec_t v);
        for (int h = 0; h < 128; h++) begin
            sample_valid = 1'b0;
            data_left    = $urandom;
            data_right   = $urandom;
            for (int j = 0; j < 3; j++) begin
                if (v.stb[j] && h == stb_hc(j)) begin
                    sample_valid = 1'b1;
                    data_left    = v.l[j];
                    data_right   = v.r[j];
                end
            end
            @(negedge clk);
        end
        sample_valid = 1'b0;
        sb.push_back(v.e);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [12];
        vec_t        v;
        logic [31:0] rl, rr;
        logic [23:0] cl, cr;
        int          sel;

        tbl[0]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 24'h000000, 24'h000000, 1'b1);
        tbl[1]  = mk(3'b001, 32'h1234_5600, 32'hABCD_EF00, 0, 0, 0, 0, 24'h123456, 24'hABCDEF, 1'b0);
        tbl[2]  = mk(3'b001, 32'hFFFF_FF00, 32'h0000_0100, 0, 0, 0, 0, 24'hFFFFFF, 24'h000001, 1'b0);
        tbl[3]  = mk(3'b001, 32'h8000_0000, 32'h7FFF_FF00, 0, 0, 0, 0, 24'h800000, 24'h7FFFFF, 1'b0);
        tbl[4]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 24'h800000, 24'h7FFFFF, 1'b1);
        tbl[5]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 24'h800000, 24'h7FFFFF, 1'b1);
        tbl[6]  = mk(3'b100, 0, 0, 0, 0, 32'hA5A5_A5FF, 32'h5A5A_5A11, 24'hA5A5A5, 24'h5A5A5A, 1'b0);
        tbl[7]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 24'hA5A5A5, 24'h5A5A5A, 1'b1);
        tbl[8]  = mk(3'b101, 32'h1111_1100, 32'h2222_2200, 0, 0, 32'h3333_3300, 32'h4444_4400,
                     24'h333333, 24'h444444, 1'b0);
        tbl[9]  = mk(3'b011, 32'h0F0F_0F00, 32'hF0F0_F000, 32'hDEAD_BE00, 32'h0BAD_F000, 0, 0,
                     24'hDEADBE, 24'h0BADF0, 1'b0);
        tbl[10] = mk(3'b100, 0, 0, 0, 0, 32'h0000_00FF, 32'hFFFF_FFFF, 24'h000000, 24'hFFFFFF, 1'b0);
        tbl[11] = mk(3'b000, 0, 0, 0, 0, 0, 0, 24'h000000, 24'hFFFFFF, 1'b1);

        repeat (3) @(negedge clk);
        chk("reset_spdif", {31'd0, spdif}, 32'd0);
        chk("reset_frame_start", {31'd0, frame_start}, 32'd0);
        chk("reset_block_start", {31'd0, block_start}, 32'd0);
        chk("reset_underrun", {31'd0, underrun}, 32'd0);

        sb.push_back('0);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) drive_frame(tbl[i]);

        // Random frames carry the run through a full block into DUT frame 10
        cl = 24'h000000;
        cr = 24'hFFFFFF;
        for (int f = 12; f < 202; f++) begin
            sel = $urandom_range(0, 5);
            rl  = $urandom;
            rr  = $urandom;
            if (sel == 0) begin
                v = mk(3'b000, 0, 0, 0, 0, 0, 0, cl, cr, 1'b1);
            end else if (sel == 1) begin
                v = mk(3'b100, 0, 0, 0, 0, rl, rr, rl[31:8], rr[31:8], 1'b0);
                cl = rl[31:8]; cr = rr[31:8];
            end else begin
                v = mk(3'b001, rl, rr, 0, 0, 0, 0, rl[31:8], rr[31:8], 1'b0);
                cl = rl[31:8]; cr = rr[31:8];
            end
            drive_frame(v);
        end

        for (int h = 0; h < 70; h++) @(negedge clk);
        for (int i = 0; i < 4 && spdif !== 1'b1; i++) @(negedge clk);
        chk("level_before_reset", {31'd0, spdif}, 32'd1);
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_reset_spdif", {31'd0, spdif}, 32'd0);
        chk("async_reset_frame_start", {31'd0, frame_start}, 32'd0);
        chk("async_reset_underrun", {31'd0, underrun}, 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        chk("held_reset_spdif", {31'd0, spdif}, 32'd0);

        sb.push_back('0);
        mon_en = 1'b1;
        rst    = 1'b1;
        for (int i = 0; i < 3; i++) drive_frame(tbl[i]);

        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
